commit_pending_tracker: RTL and testbench

- Fetch-side consumer of the commit-to-fetch interface. Counts instructions issued but not yet committed.
- Increments on each issue handshake. Decrements by the per-cycle committed count from the commit stage.
- Provides a drain handshake so fence, barrier and ebreak paths can stall new issue until the pipeline has fully retired.
- Sits between the fetch/issue control and the commit stage.

---
 rtl/commit_pending_tracker_if.sv | 27 ++
 rtl/commit_pending_tracker.sv | 78 +++++++
 tb/tb_commit_pending_tracker.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/commit_pending_tracker_if.sv
// Commit-to-fetch tracking bus: issue handshake, commit report, drain handshake and status.
// issue fires only on a cycle where issue_valid && issue_ready; cmt_valid has no backpressure.
interface commit_pending_tracker_if #(
    parameter int CMT_W = 3,
    parameter int CTR_W = 8
);
    logic             issue_valid;
    logic             issue_ready;
    logic             cmt_valid;
    logic [CMT_W-1:0] cmt_committed;
    logic             drain_req;
    logic             drain_ack;
    logic [CTR_W-1:0] pending;
    logic             empty;
    logic             full;
    logic             err;

    modport master (
        output issue_valid, cmt_valid, cmt_committed, drain_req,
        input  issue_ready, drain_ack, pending, empty, full, err
    );

    modport slave (
        input  issue_valid, cmt_valid, cmt_committed, drain_req,
        output issue_ready, drain_ack, pending, empty, full, err
    );
endinterface

// File: rtl/commit_pending_tracker.sv
// Counts issued-but-uncommitted instructions and runs the drain handshake that
// lets fence/barrier/ebreak paths wait for the pipeline to fully retire.
module commit_pending_tracker #(
    parameter int NUM_EX_UNITS = 6,
    parameter int CMT_W        = $clog2(NUM_EX_UNITS + 1),
    parameter int CTR_W        = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    commit_pending_tracker_if.slave   bus,
    output logic [1:0]                state_o
);
    localparam int SW = CTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        ACK   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CTR_W-1:0] pending_q, pending_d;
    logic             err_q, err_d;

    logic             empty, full, issue_ready, issue_fire;
    logic [SW-1:0]    inc_w, dec_w, sum_w;
    logic             underflow;

    assign empty       = (pending_q == '0);
    assign full        = (pending_q == {CTR_W{1'b1}});
    assign issue_ready = !full && (state_q == IDLE) && !bus.drain_req;
    assign issue_fire  = bus.issue_valid && issue_ready;

    // Extra headroom bit so the underflow test sees the true signed result.
    always_comb begin
        inc_w     = SW'(issue_fire);
        dec_w     = bus.cmt_valid ? SW'(bus.cmt_committed) : '0;
        sum_w     = SW'(pending_q) + inc_w;
        underflow = (dec_w > sum_w);
        pending_d = underflow ? '0 : CTR_W'(sum_w - dec_w);
        err_d     = err_q || underflow;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic; a drain cannot be cancelled once started.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.drain_req) state_d = DRAIN;
            DRAIN:   if (empty)         state_d = ACK;
            ACK:                        state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.drain_ack   = (state_q == ACK);
        bus.issue_ready = issue_ready;
        bus.pending     = pending_q;
        bus.empty       = empty;
        bus.full        = full;
        bus.err         = err_q;
        state_o         = state_q;
    end
endmodule

// File: tb/tb_commit_pending_tracker.sv
// Directed bench for commit_pending_tracker (CTR_W=3 so the full boundary is reachable).
module tb_commit_pending_tracker;
    localparam int NUM_EX = 6;
    localparam int CMT_W  = 3;
    localparam int CTR_W  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] state;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [31:0] exp_q[$];

    commit_pending_tracker_if #(.CMT_W(CMT_W), .CTR_W(CTR_W)) bus ();

    commit_pending_tracker #(.NUM_EX_UNITS(NUM_EX), .CTR_W(CTR_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .state_o (state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // advance one active edge and settle past it
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic cv, input logic [CMT_W-1:0] cc, input logic dr);
        bus.issue_valid   = iv;
        bus.cmt_valid     = cv;
        bus.cmt_committed = cc;
        bus.drain_req     = dr;
    endtask

    initial begin
        drive(0, 0, 0, 0);
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        check("rst_pending", bus.pending, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_ready", bus.issue_ready, 1);
        check("rst_ack", bus.drain_ack, 0);
        check("rst_err", bus.err, 0);
        check("rst_state", state, 0);

        // five issues, then commits of 3 and 2
        for (int i = 1; i <= 5; i++) exp_q.push_back(i);
        drive(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("inc_pending", bus.pending, exp_q.pop_front());
        end
        drive(0, 1, 3, 0);
        cyc();
        check("cmt3_pending", bus.pending, 2);
        drive(0, 1, 2, 0);
        cyc();
        check("cmt2_pending", bus.pending, 0);
        check("cmt2_empty", bus.empty, 1);

        // simultaneous issue and commit from pending=4
        drive(1, 0, 0, 0);
        repeat (4) cyc();
        check("sim_pre", bus.pending, 4);
        drive(1, 1, 1, 0);
        cyc();
        check("sim_inc_cmt1", bus.pending, 4);
        drive(1, 1, 3, 0);
        cyc();
        check("sim_inc_cmt3", bus.pending, 2);
        drive(0, 1, 0, 0);
        cyc();
        check("cmt_zero", bus.pending, 2);
        drive(0, 0, 5, 0);
        cyc();
        check("cmt_invalid_ignored", bus.pending, 2);
        drive(0, 1, 2, 0);
        cyc();
        check("sim_clear", bus.pending, 0);

        // fill to full; held issue_valid is not counted
        drive(1, 0, 0, 0);
        repeat (7) cyc();
        check("full_pending", bus.pending, 7);
        check("full_flag", bus.full, 1);
        check("full_ready", bus.issue_ready, 0);
        cyc();
        check("full_hold", bus.pending, 7);
        drive(1, 1, 1, 0);
        cyc();
        check("full_cmt_pending", bus.pending, 6);
        check("full_cmt_flag", bus.full, 0);
        check("full_cmt_ready", bus.issue_ready, 1);
        drive(0, 1, 6, 0);
        cyc();
        check("full_clear", bus.pending, 0);

        // drain with pending=3
        drive(1, 0, 0, 0);
        repeat (3) cyc();
        check("drn_pre", bus.pending, 3);
        drive(1, 0, 0, 1);
        #1;
        check("drn_ready_same_cycle", bus.issue_ready, 0);
        cyc();
        check("drn_state", state, 1);
        check("drn_no_issue", bus.pending, 3);
        drive(0, 1, 1, 1);
        cyc();
        check("drn_cmt1", bus.pending, 2);
        check("drn_ack_early1", bus.drain_ack, 0);
        drive(0, 1, 2, 1);
        cyc();
        check("drn_cmt2", bus.pending, 0);
        check("drn_ack_early2", bus.drain_ack, 0);
        drive(0, 0, 0, 1);
        cyc();
        check("drn_ack", bus.drain_ack, 1);
        check("drn_ack_ready", bus.issue_ready, 0);
        drive(0, 0, 0, 0);
        cyc();
        check("drn_ack_once", bus.drain_ack, 0);
        check("drn_idle", state, 0);
        check("drn_ready_back", bus.issue_ready, 1);

        // drain with pending=0: ack two cycles after request
        drive(0, 0, 0, 1);
        cyc();
        check("drn0_t1_ack", bus.drain_ack, 0);
        cyc();
        check("drn0_t2_ack", bus.drain_ack, 1);
        drive(0, 0, 0, 0);
        cyc();
        check("drn0_t3_ack", bus.drain_ack, 0);

        // request dropped mid-drain still completes
        drive(1, 0, 0, 0);
        cyc();
        drive(0, 0, 0, 1);
        cyc();
        drive(0, 0, 0, 0);
        cyc();
        check("drop_still_drain", state, 1);
        drive(0, 1, 1, 0);
        cyc();
        drive(0, 0, 0, 0);
        check("drop_pending0", bus.pending, 0);
        cyc();
        check("drop_ack", bus.drain_ack, 1);
        cyc();
        check("drop_idle", state, 0);

        // underflow from pending=1
        drive(1, 0, 0, 0);
        cyc();
        drive(0, 1, 3, 0);
        cyc();
        check("uf_pending", bus.pending, 0);
        check("uf_err", bus.err, 1);
        drive(1, 0, 0, 0);
        repeat (2) cyc();
        check("uf_traffic_pending", bus.pending, 2);
        check("uf_err_sticky", bus.err, 1);
        drive(0, 0, 0, 0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("uf_err_reset", bus.err, 0);

        // reset mid-drain
        drive(1, 0, 0, 0);
        repeat (2) cyc();
        drive(0, 0, 0, 1);
        cyc();
        check("rmd_state_drain", state, 1);
        check("rmd_pending", bus.pending, 2);
        drive(0, 0, 0, 0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("rmd_pending0", bus.pending, 0);
        check("rmd_state_idle", state, 0);
        check("rmd_err", bus.err, 0);
        for (int i = 0; i < 4; i++) begin
            check("rmd_no_ack", bus.drain_ack, 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
